clk_div_ctrl: RTL

//   Run-time controller for the clock-divider counter path. Sequences a

---
 rtl/clk_div_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable modulo-N divider controller.
// Produces a divided enable (high for H of every N cycles) and a terminal-count
// tick, and accepts new N/H over a valid/ready handshake. A new setting only
// takes effect at a period boundary, so the divided waveform never glitches.
module clk_div_ctrl #(
  parameter int W        = 4,
  parameter int DEF_DIV  = 10,
  parameter int DEF_HIGH = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  input  logic [W-1:0] cfg_high,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         running,
  output logic [W-1:0] count,
  output logic         div_out,
  output logic         tick
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [W-1:0] DEF_DIV_C  = W'(DEF_DIV);
  localparam logic [W-1:0] DEF_HIGH_C = W'(DEF_HIGH);

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   div_q, div_d;
  logic [W-1:0]   high_q, high_d;
  logic           pend_q, pend_d;
  logic [W-1:0]   pdiv_q, pdiv_d;
  logic [W-1:0]   phigh_q, phigh_d;
  logic           cfg_ready_q;
  logic           cfg_err_q;

  logic           run_now;
  logic           wrap;
  logic           xfer;
  logic           cfg_good;

  // A setting is usable only if the period has at least two cycles and the
  // high time is a non-empty strict subset of it.
  function automatic logic cfg_ok(input logic [W-1:0] d, input logic [W-1:0] h);
    return (d >= W'(2)) && (h >= W'(1)) && (h < d);
  endfunction

  assign run_now  = (state_q != S_IDLE);
  assign wrap     = run_now && (count_q == div_q - W'(1));
  assign xfer     = cfg_valid && cfg_ready_q;
  assign cfg_good = cfg_ok(cfg_div, cfg_high);

  // Next-state logic: sequencing, counting and config staging.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    high_d  = high_q;
    pend_d  = pend_q;
    pdiv_d  = pdiv_q;
    phigh_d = phigh_q;

    case (state_q)
      S_IDLE: begin
        // count stays 0 on the first RUN cycle so a period is exactly N cycles
        count_d = '0;
        if (start && !stop) state_d = S_RUN;
      end
      S_RUN: begin
        count_d = wrap ? '0 : count_q + W'(1);
        if (stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        count_d = wrap ? '0 : count_q + W'(1);
        if (start && !stop) state_d = S_RUN;
        else if (wrap)      state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    if (state_q == S_IDLE) begin
      // No waveform in flight: a staged setting (left over from a final
      // drain wrap) or a fresh one is applied immediately.
      if (pend_q) begin
        div_d  = pdiv_q;
        high_d = phigh_q;
        pend_d = 1'b0;
      end
      if (xfer && cfg_good) begin
        div_d  = cfg_div;
        high_d = cfg_high;
      end
    end else begin
      if (wrap && pend_q) begin
        div_d  = pdiv_q;
        high_d = phigh_q;
        pend_d = 1'b0;
      end
      // A transfer on the wrap cycle is staged for the following boundary.
      if (xfer && cfg_good) begin
        pend_d  = 1'b1;
        pdiv_d  = cfg_div;
        phigh_d = cfg_high;
      end
    end
  end

  // State and configuration registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      div_q       <= DEF_DIV_C;
      high_q      <= DEF_HIGH_C;
      pend_q      <= 1'b0;
      pdiv_q      <= '0;
      phigh_q     <= '0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      div_q       <= div_d;
      high_q      <= high_d;
      pend_q      <= pend_d;
      pdiv_q      <= pdiv_d;
      phigh_q     <= phigh_d;
      cfg_ready_q <= !pend_d;
      cfg_err_q   <= xfer && !cfg_good;
    end
  end

  // Outputs decode registers only; no input reaches an output combinationally.
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign running   = run_now;
  assign count     = count_q;
  assign div_out   = run_now && (count_q < high_q);
  assign tick      = wrap;

endmodule
